// File: rtl/adc_scan_sequencer.sv
// adc_scan_sequencer: timed multi-channel scan controller for the ADC command/response stream.
// Optional macro ADC_TIMEOUT_EN adds a wait counter and the sticky timeout_err output.
module adc_scan_sequencer #(
   parameter int DIVIDER = 6250,
   parameter int NUM_CH  = 1,
   parameter int CH_BASE = 0,
   parameter int TIMEOUT = 1024
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic        clear_flags,
   output logic        command_valid,
   output logic [4:0]  command_channel,
   output logic        command_startofpacket,
   output logic        command_endofpacket,
   input  logic        command_ready,
   input  logic        response_valid,
   input  logic [4:0]  response_channel,
   input  logic [11:0] response_data,
   output logic        sample_valid,
   output logic [11:0] sample_data,
   output logic [4:0]  sample_channel,
   output logic        sample_last,
   output logic        busy,
   output logic        overrun,
   output logic        ch_err
`ifdef ADC_TIMEOUT_EN
   ,
   output logic        timeout_err
`endif
);

   typedef enum logic [1:0] {
      IDLE,
      CMD,
      RSP
   } state_t;

   localparam logic [19:0] TICK_AT  = 20'(DIVIDER - 1);
   localparam logic [2:0]  LAST_IDX = 3'(NUM_CH - 1);
   localparam logic [4:0]  BASE_CH  = 5'(CH_BASE);

   if (DIVIDER < 2 || DIVIDER > 1048575) begin : g_bad_div
      $error("DIVIDER out of range");
   end
   if (NUM_CH < 1 || NUM_CH > 8) begin : g_bad_num
      $error("NUM_CH out of range");
   end
   if (CH_BASE < 0 || CH_BASE + NUM_CH > 32) begin : g_bad_base
      $error("CH_BASE out of range");
   end
   if (TIMEOUT < 1) begin : g_bad_tmo
      $error("TIMEOUT must be positive");
   end

   state_t      state;
   logic [19:0] cnt;
   logic [2:0]  idx;
   logic        tick;

`ifdef ADC_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT) + 1;
   localparam logic [TW-1:0] WAIT_LAST = TW'(TIMEOUT - 1);
   logic [TW-1:0] wcnt;
`endif

   assign tick = (cnt == TICK_AT);
   assign busy = (state != IDLE);

   // Free-running scan-rate divider, independent of enable
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt <= '0;
      end else if (tick) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 20'd1;
      end
   end

   // Scan FSM with registered command, sample and flag outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state                 <= IDLE;
         idx                   <= '0;
         command_valid         <= 1'b0;
         command_channel       <= '0;
         command_startofpacket <= 1'b0;
         command_endofpacket   <= 1'b0;
         sample_valid          <= 1'b0;
         sample_data           <= '0;
         sample_channel        <= '0;
         sample_last           <= 1'b0;
         overrun               <= 1'b0;
         ch_err                <= 1'b0;
`ifdef ADC_TIMEOUT_EN
         timeout_err           <= 1'b0;
         wcnt                  <= '0;
`endif
      end else begin
         sample_valid <= 1'b0;
         sample_last  <= 1'b0;
         // clear first so a same-cycle set below takes priority
         if (clear_flags) begin
            overrun <= 1'b0;
            ch_err  <= 1'b0;
`ifdef ADC_TIMEOUT_EN
            timeout_err <= 1'b0;
`endif
         end
         if (tick && state != IDLE) begin
            overrun <= 1'b1;
         end
         unique case (state)
            IDLE: begin
               if (tick && enable) begin
                  idx                   <= '0;
                  state                 <= CMD;
                  command_valid         <= 1'b1;
                  command_channel       <= BASE_CH;
                  command_startofpacket <= 1'b1;
                  command_endofpacket   <= 1'b1;
`ifdef ADC_TIMEOUT_EN
                  wcnt <= '0;
`endif
               end
            end
            CMD: begin
               if (command_ready) begin
                  state                 <= RSP;
                  command_valid         <= 1'b0;
                  command_channel       <= '0;
                  command_startofpacket <= 1'b0;
                  command_endofpacket   <= 1'b0;
`ifdef ADC_TIMEOUT_EN
                  wcnt <= '0;
               end else if (wcnt == WAIT_LAST) begin
                  state                 <= IDLE;
                  command_valid         <= 1'b0;
                  command_channel       <= '0;
                  command_startofpacket <= 1'b0;
                  command_endofpacket   <= 1'b0;
                  timeout_err           <= 1'b1;
               end else begin
                  wcnt <= wcnt + 1'b1;
`endif
               end
            end
            RSP: begin
               if (response_valid) begin
                  sample_valid   <= 1'b1;
                  sample_data    <= response_data;
                  sample_channel <= response_channel;
                  sample_last    <= (idx == LAST_IDX);
                  if (response_channel != BASE_CH + {2'b00, idx}) begin
                     ch_err <= 1'b1;
                  end
                  if (idx != LAST_IDX) begin
                     idx                   <= idx + 3'd1;
                     state                 <= CMD;
                     command_valid         <= 1'b1;
                     command_channel       <= BASE_CH + {2'b00, idx + 3'd1};
                     command_startofpacket <= 1'b1;
                     command_endofpacket   <= 1'b1;
`ifdef ADC_TIMEOUT_EN
                     wcnt <= '0;
`endif
                  end else begin
                     state <= IDLE;
                  end
`ifdef ADC_TIMEOUT_EN
               end else if (wcnt == WAIT_LAST) begin
                  state       <= IDLE;
                  timeout_err <= 1'b1;
               end else begin
                  wcnt <= wcnt + 1'b1;
`endif
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
